note_recorder: RTL and testbench
================================

Name: note_recorder

Overview:
- Records the user's live note codes into a buffer, one sample per quarter beat.
- Replays the recorded sequence on the same note-code bus that feeds the tone generator. It is the write-side counterpart of the fixed-song auto player.
- Sits between the keyboard note encoder and the tone-generator note mux.
- Note code 4'd0 means silence ("none"). Codes 1-15 are pitches.

Parameters:
- DEPTH, 64, number of quarter-beat slots in the buffer. Must be a power of two, 2..256.
- AW, $clog2(DEPTH), buffer address width. Derived; do not override.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  reset. Asynchronous, active-high.
- QUARTER_TICK  input  1  one-CLK-cycle pulse per quarter beat.
- REC_START  input  1  one-cycle pulse (debounced): begin a new recording.
- PLAY_START  input  1  one-cycle pulse (debounced): begin playback.
- STOP  input  1  one-cycle pulse (debounced): abort recording or playback.
- LIVE_NOTE  input  4  current keyboard note code; sampled on QUARTER_TICK while recording.
- play_note  output  4  registered playback note code; 0 when not playing.
- rec_active  output  1  high in RECORD state.
- play_active  output  1  high in PLAY state.
- full  output  1  high while rec_len == DEPTH.
- rec_len  output  AW+1  number of valid recorded slots, 0..DEPTH.

Behaviour:
- Storage:
  - DEPTH x 4 register array, written only in RECORD.
  - Contents are not cleared by reset. rec_len alone defines validity.
- Reset: state=IDLE; play_note=0; rec_len=0; wr_ptr=0; rd_ptr=0; all flags 0. Takes effect immediately, including mid-record or mid-play.
- States: IDLE, RECORD, PLAY (2-bit encoded).
- rec_active / play_active / full are registered, or decoded from registered state; no combinational path from inputs.
- IDLE:
  - REC_START -> RECORD; wr_ptr<=0; rec_len<=0.
  - PLAY_START with rec_len>0 -> PLAY; rd_ptr<=0; play_note stays 0.
  - PLAY_START with rec_len==0 is ignored.
  - REC_START and PLAY_START in the same cycle: REC_START wins.
  - STOP and QUARTER_TICK have no effect.
- RECORD:
  - On QUARTER_TICK: mem[wr_ptr]<=LIVE_NOTE; wr_ptr<=wr_ptr+1; rec_len<=rec_len+1.
  - If that write makes rec_len==DEPTH -> IDLE (full=1). wr_ptr wraps to 0 and is unused.
  - STOP -> IDLE with rec_len kept. If STOP and QUARTER_TICK coincide, the sample is written and counted first, then IDLE.
  - REC_START restarts the take: wr_ptr<=0, rec_len<=0. If it coincides with QUARTER_TICK, the restart wins and no write occurs.
  - PLAY_START is ignored.
  - A tick in the same cycle as the REC_START that entered RECORD is not sampled. First sample is on the next tick.
- PLAY:
  - On QUARTER_TICK with rd_ptr<rec_len: play_note<=mem[rd_ptr]; rd_ptr<=rd_ptr+1. The first note appears one CLK after the first tick following entry.
  - On QUARTER_TICK with rd_ptr==rec_len (end): play_note<=0; state -> IDLE. Default build; see Optional Feature.
  - STOP -> IDLE; play_note<=0 on the same edge. STOP beats a coincident tick.
  - REC_START is ignored; PLAY_START restarts playback (rd_ptr<=0, play_note<=0).
- Widths: rd_ptr and rec_len are AW+1 bits so the value DEPTH is representable. Memory is indexed with the low AW bits.
- full = (rec_len==DEPTH). It clears only when a new REC_START resets rec_len.

Optional Feature:
- Macro: NOTE_RECORDER_LOOP_EN.
- Defined: at end of sequence (tick with rd_ptr==rec_len), play_note<=mem[0] and rd_ptr<=1. Playback repeats seamlessly until STOP or PLAY_START, with no silent slot between loops.
- Undefined: playback ends as described above (play_note=0, return to IDLE).

Test Plan:
1. Reset: assert RESET mid-PLAY with play_note=5 -> same cycle play_note=0, play_active=0, rec_len=0, state IDLE; PLAY_START then ignored.
2. Record: REC_START, then ticks with LIVE_NOTE=3,5,0, then STOP -> rec_len=3, rec_active 1->0, full=0.
3. Playback (loop off): PLAY_START, then 4 ticks -> play_note 0 until tick 1, then 3, 5, 0. On tick 4, play_note=0 and play_active=0.
4. Full: REC_START, 64 ticks with LIVE_NOTE=7 -> after 64th tick rec_len=64, full=1, rec_active=0. 65th tick changes nothing.
5. Coincidence: in RECORD with rec_len=2, STOP+QUARTER_TICK together with LIVE_NOTE=9 -> rec_len=3, slot 2 plays back as 9. In PLAY, STOP+tick -> play_note=0, no advance.
6. Loop on (NOTE_RECORDER_LOOP_EN): record 2,4 then play 5 ticks -> play_note 2,4,2,4,2; play_active stays 1 until STOP.

Source files
------------

// File: rtl/note_recorder.sv
// Quarter-beat note recorder/player: captures LIVE_NOTE into a DEPTH-slot buffer, replays it on play_note.
// Optional NOTE_RECORDER_LOOP_EN: playback wraps to slot 0 seamlessly instead of ending.
module note_recorder #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          QUARTER_TICK,
  input  logic          REC_START,
  input  logic          PLAY_START,
  input  logic          STOP,
  input  logic [3:0]    LIVE_NOTE,
  output logic [3:0]    play_note,
  output logic          rec_active,
  output logic          play_active,
  output logic          full,
  output logic [AW:0]   rec_len
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REC = 2'd1, S_PLAY = 2'd2} state_t;

  localparam logic [AW:0] LEN_MAX  = DEPTH[AW:0];
  localparam logic [AW:0] LEN_LAST = LEN_MAX - 1'b1;

  state_t              r_state;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [AW:0]         r_rec_len;
  logic [3:0]          r_play_note;
  logic [3:0]          r_mem [DEPTH];
  logic                w_wr_en;

  // A REC_START restart suppresses any coincident sample.
  assign w_wr_en = (r_state == S_REC) && QUARTER_TICK && !REC_START;

  // Buffer contents survive reset; rec_len alone marks what is valid.
  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= LIVE_NOTE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rec_len   <= '0;
      r_play_note <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (REC_START) begin
            r_state   <= S_REC;
            r_wr_ptr  <= '0;
            r_rec_len <= '0;
          end else if (PLAY_START && (r_rec_len != '0)) begin
            r_state  <= S_PLAY;
            r_rd_ptr <= '0;
          end
        end
        S_REC: begin
          if (REC_START) begin
            r_wr_ptr  <= '0;
            r_rec_len <= '0;
          end else begin
            if (QUARTER_TICK) begin
              r_wr_ptr  <= r_wr_ptr + 1'b1;
              r_rec_len <= r_rec_len + 1'b1;
              if (r_rec_len == LEN_LAST) r_state <= S_IDLE;
            end
            if (STOP) r_state <= S_IDLE;
          end
        end
        S_PLAY: begin
          if (STOP) begin
            r_state     <= S_IDLE;
            r_play_note <= '0;
          end else if (PLAY_START) begin
            r_rd_ptr    <= '0;
            r_play_note <= '0;
          end else if (QUARTER_TICK) begin
            if (r_rd_ptr < r_rec_len) begin
              r_play_note <= r_mem[r_rd_ptr[AW-1:0]];
              r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else begin
`ifdef NOTE_RECORDER_LOOP_EN
              r_play_note <= r_mem[0];
              r_rd_ptr    <= {{AW{1'b0}}, 1'b1};
`else
              r_play_note <= '0;
              r_state     <= S_IDLE;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign play_note   = r_play_note;
  assign rec_len     = r_rec_len;
  assign rec_active  = (r_state == S_REC);
  assign play_active = (r_state == S_PLAY);
  assign full        = (r_rec_len == LEN_MAX);

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder (DEPTH=64); loop-mode scenario selected by NOTE_RECORDER_LOOP_EN.
module tb_note_recorder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, rec_s = 1'b0, play_s = 1'b0, stop = 1'b0;
  logic [3:0] live = 4'd0;
  logic [3:0] play_note;
  logic       rec_active, play_active, full;
  logic [6:0] rec_len;
  int         errors = 0;
  int         checks = 0;

  note_recorder #(.DEPTH(64)) dut (
    .CLK(clk), .RESET(rst), .QUARTER_TICK(tick), .REC_START(rec_s), .PLAY_START(play_s),
    .STOP(stop), .LIVE_NOTE(live), .play_note(play_note), .rec_active(rec_active),
    .play_active(play_active), .full(full), .rec_len(rec_len)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then release them 1 time unit after the edge.
  task automatic step(input logic rs, input logic ps, input logic st, input logic tk, input logic [3:0] n);
    rec_s = rs; play_s = ps; stop = st; tick = tk; live = n;
    @(posedge clk); #1;
    rec_s = 0; play_s = 0; stop = 0; tick = 0; live = 0;
  endtask

  task automatic test_reset_initial;
    #2;
    checks++; if (play_note !== 4'd0) begin errors++; $display("FAIL rst_play_note got=%0d exp=0", play_note); end
    checks++; if (rec_len !== 7'd0) begin errors++; $display("FAIL rst_rec_len got=%0d exp=0", rec_len); end
    checks++; if ({rec_active, play_active, full} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {rec_active, play_active, full}); end
    @(negedge clk); rst = 0;
    step(0, 1, 0, 0, 0);
    checks++; if (play_active !== 1'b0) begin errors++; $display("FAIL play_empty_ignored got=%b exp=0", play_active); end
  endtask

  task automatic test_record;
    step(1, 0, 0, 1, 4'd9);   // tick coincident with entry is not sampled
    checks++; if (rec_active !== 1'b1 || rec_len !== 7'd0) begin errors++; $display("FAIL rec_enter got=%b/%0d exp=1/0", rec_active, rec_len); end
    step(0, 0, 0, 1, 4'd3);
    step(0, 1, 0, 1, 4'd5);   // PLAY_START ignored while recording
    checks++; if (rec_len !== 7'd2 || rec_active !== 1'b1) begin errors++; $display("FAIL rec_mid got=%0d/%b exp=2/1", rec_len, rec_active); end
    step(0, 0, 0, 1, 4'd0);
    step(0, 0, 1, 0, 4'd0);
    checks++; if (rec_len !== 7'd3) begin errors++; $display("FAIL rec_len got=%0d exp=3", rec_len); end
    checks++; if (rec_active !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL rec_stop got=%b/%b exp=0/0", rec_active, full); end
  endtask

  task automatic test_playback;
    logic [3:0] exp [4];
    exp[0] = 4'd3; exp[1] = 4'd5; exp[2] = 4'd0; exp[3] = 4'd0;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (play_active !== 1'b1 || play_note !== 4'd0) begin errors++; $display("FAIL play_enter got=%b/%0d exp=1/0", play_active, play_note); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      checks++; if (play_note !== exp[i]) begin errors++; $display("FAIL play_tick%0d got=%0d exp=%0d", i + 1, play_note, exp[i]); end
      checks++; if (play_active !== (i < 3)) begin errors++; $display("FAIL play_active%0d got=%b exp=%b", i + 1, play_active, (i < 3)); end
    end
  endtask

  task automatic test_reset_midplay;
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++; if (play_note !== 4'd5) begin errors++; $display("FAIL pre_reset_note got=%0d exp=5", play_note); end
    #2 rst = 1; #1;
    checks++; if (play_note !== 4'd0 || play_active !== 1'b0 || rec_len !== 7'd0) begin
      errors++; $display("FAIL async_reset got=%0d/%b/%0d exp=0/0/0", play_note, play_active, rec_len); end
    @(negedge clk); rst = 0;
    step(0, 1, 0, 0, 0);
    checks++; if (play_active !== 1'b0) begin errors++; $display("FAIL post_reset_play got=%b exp=0", play_active); end
  endtask

  task automatic test_full;
    step(1, 1, 0, 0, 0);      // REC_START beats PLAY_START
    checks++; if (rec_active !== 1'b1 || play_active !== 1'b0) begin errors++; $display("FAIL rec_wins got=%b/%b exp=1/0", rec_active, play_active); end
    for (int i = 0; i < 63; i++) step(0, 0, 0, 1, 4'd7);
    checks++; if (rec_len !== 7'd63 || full !== 1'b0 || rec_active !== 1'b1) begin errors++; $display("FAIL full_63 got=%0d/%b/%b exp=63/0/1", rec_len, full, rec_active); end
    step(0, 0, 0, 1, 4'd7);
    checks++; if (rec_len !== 7'd64 || full !== 1'b1 || rec_active !== 1'b0) begin errors++; $display("FAIL full_64 got=%0d/%b/%b exp=64/1/0", rec_len, full, rec_active); end
    step(0, 0, 0, 1, 4'd7);
    checks++; if (rec_len !== 7'd64 || full !== 1'b1 || rec_active !== 1'b0) begin errors++; $display("FAIL full_65 got=%0d/%b/%b exp=64/1/0", rec_len, full, rec_active); end
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    checks++; if (play_note !== 4'd7) begin errors++; $display("FAIL full_play got=%0d exp=7", play_note); end
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_coincide;
    logic [3:0] exp [3];
    exp[0] = 4'd1; exp[1] = 4'd2; exp[2] = 4'd9;
    step(1, 0, 0, 0, 0);
    checks++; if (full !== 1'b0 || rec_len !== 7'd0) begin errors++; $display("FAIL full_clear got=%b/%0d exp=0/0", full, rec_len); end
    step(0, 0, 0, 1, 4'd1);
    step(0, 0, 0, 1, 4'd2);
    step(0, 0, 1, 1, 4'd9);
    checks++; if (rec_len !== 7'd3 || rec_active !== 1'b0) begin errors++; $display("FAIL stop_tick_rec got=%0d/%b exp=3/0", rec_len, rec_active); end
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      checks++; if (play_note !== exp[i]) begin errors++; $display("FAIL coin_play%0d got=%0d exp=%0d", i, play_note, exp[i]); end
    end
    step(0, 0, 1, 1, 0);
    checks++; if (play_note !== 4'd0 || play_active !== 1'b0) begin errors++; $display("FAIL stop_tick_play got=%0d/%b exp=0/0", play_note, play_active); end
  endtask

  task automatic test_restart;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4'd4);
    step(1, 0, 0, 1, 4'd6);   // restart wins over the coincident sample
    checks++; if (rec_len !== 7'd0 || rec_active !== 1'b1) begin errors++; $display("FAIL rec_restart got=%0d/%b exp=0/1", rec_len, rec_active); end
    step(0, 0, 0, 1, 4'd8);
    step(0, 0, 0, 1, 4'd11);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    checks++; if (play_note !== 4'd11) begin errors++; $display("FAIL restart_note2 got=%0d exp=11", play_note); end
    step(1, 1, 0, 0, 0);      // PLAY_START restarts; REC_START ignored in PLAY
    checks++; if (play_note !== 4'd0 || play_active !== 1'b1 || rec_active !== 1'b0) begin
      errors++; $display("FAIL play_restart got=%0d/%b/%b exp=0/1/0", play_note, play_active, rec_active); end
    step(0, 0, 0, 1, 0);
    checks++; if (play_note !== 4'd8) begin errors++; $display("FAIL play_restart_note got=%0d exp=8", play_note); end
    step(0, 0, 1, 0, 0);
  endtask

  task automatic test_loop;
    logic [3:0] exp [5];
    exp[0] = 4'd2; exp[1] = 4'd4; exp[2] = 4'd2; exp[3] = 4'd4; exp[4] = 4'd2;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4'd2);
    step(0, 0, 0, 1, 4'd4);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0);
      checks++; if (play_note !== exp[i]) begin errors++; $display("FAIL loop_tick%0d got=%0d exp=%0d", i + 1, play_note, exp[i]); end
      checks++; if (play_active !== 1'b1) begin errors++; $display("FAIL loop_active%0d got=%b exp=1", i + 1, play_active); end
    end
    step(0, 0, 1, 0, 0);
    checks++; if (play_active !== 1'b0 || play_note !== 4'd0) begin errors++; $display("FAIL loop_stop got=%b/%0d exp=0/0", play_active, play_note); end
  endtask

  initial begin
    test_reset_initial;
    test_record;
`ifdef NOTE_RECORDER_LOOP_EN
    test_loop;
    test_record;
`else
    test_playback;
`endif
    test_reset_midplay;
    test_full;
    test_coincide;
    test_restart;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
